// File: rtl/datapath_ctrl.sv
// Multicycle IDLE/EXEC/WB sequencer that decodes one 16-bit instruction into regfile/ALU controls.
// Optional macro DATAPATH_CTRL_FAST_ISSUE_EN lets WB accept the next instruction (2-clock issue).
module datapath_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] raddr_a,
  output logic [AW-1:0] raddr_b,
  output logic [AW-1:0] waddr,
  output logic          reg_we,
  output logic          flag_we,
  output logic          ri,
  output logic [DW-1:0] imm,
  output logic [3:0]    alu_op,
  output logic          done,
  output logic          illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_instr;
  logic        r_started;
  logic        w_ready;
  logic        w_accept;

  logic [3:0]  w_op;
  logic [3:0]  w_opext;
  logic [7:0]  w_field;
  logic        w_ri;
  logic [DW-1:0] w_imm;
  logic [3:0]  w_alu_op;
  logic        w_rwe;
  logic        w_fwe;
  logic        w_legal;

  // r_started holds instr_ready low for the first cycle after reset release.
`ifdef DATAPATH_CTRL_FAST_ISSUE_EN
  assign w_ready = r_started && ((r_state == S_IDLE) || (r_state == S_WB));
`else
  assign w_ready = r_started && (r_state == S_IDLE);
`endif
  assign w_accept = instr_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_started <= 1'b1;
      if (w_accept) begin
        r_instr <= instr;
      end
    end
  end

  always_comb begin
    w_state_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_next = w_accept ? S_EXEC : S_IDLE;
      S_EXEC:  w_state_next = S_WB;
      S_WB:    w_state_next = w_accept ? S_EXEC : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_op    = r_instr[15:12];
  assign w_opext = r_instr[7:4];
  assign w_field = r_instr[7:0];

  always_comb begin
    w_ri     = 1'b1;
    w_imm    = '0;
    w_alu_op = w_op;
    w_rwe    = 1'b1;
    w_fwe    = 1'b1;
    w_legal  = 1'b1;
    case (w_op)
      4'b0000: begin
        // Undefined opext values are forwarded; the ALU decides what they mean.
        w_ri     = 1'b0;
        w_alu_op = w_opext;
        w_rwe    = (w_opext != 4'b1011);
      end
      4'b0101, 4'b1001: begin
        w_imm = {{(DW-8){w_field[7]}}, w_field};
      end
      4'b1011: begin
        w_imm = {{(DW-8){w_field[7]}}, w_field};
        w_rwe = 1'b0;
      end
      4'b0001, 4'b0010, 4'b0011: begin
        w_imm = {{(DW-8){1'b0}}, w_field};
      end
      4'b1101: begin
        w_imm = {{(DW-8){1'b0}}, w_field};
        w_fwe = 1'b0;
      end
      4'b1111: begin
        w_imm = {w_field, {(DW-8){1'b0}}};
        w_fwe = 1'b0;
      end
      default: begin
        w_ri    = 1'b0;
        w_rwe   = 1'b0;
        w_fwe   = 1'b0;
        w_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    instr_ready = w_ready;
    raddr_a     = AW'(r_instr[11:8]);
    raddr_b     = AW'(r_instr[3:0]);
    waddr       = AW'(r_instr[11:8]);
    ri          = w_ri;
    imm         = w_imm;
    alu_op      = w_alu_op;
    reg_we      = 1'b0;
    flag_we     = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    if (r_state == S_WB) begin
      reg_we  = w_legal && w_rwe;
      flag_we = w_legal && w_fwe;
      done    = w_legal;
      illegal = !w_legal;
    end
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: expected decode/writeback pushed at accept, popped at WB.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  raddr_a, raddr_b, waddr;
  logic        reg_we, flag_we, ri, done, illegal;
  logic [15:0] imm;
  logic [3:0]  alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic        ri;
    logic [15:0] imm;
    logic [3:0]  alu;
    logic        rwe;
    logic        fwe;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  logic [37:0] all_outs;
  logic [32:0] dec_obs;
  assign all_outs = {instr_ready, raddr_a, raddr_b, waddr, reg_we, flag_we, ri, imm, alu_op, done, illegal};
  assign dec_obs  = {raddr_a, raddr_b, waddr, ri, imm, alu_op};

`ifdef DATAPATH_CTRL_FAST_ISSUE_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  datapath_ctrl #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .raddr_a(raddr_a), .raddr_b(raddr_b), .waddr(waddr),
    .reg_we(reg_we), .flag_we(flag_we), .ri(ri), .imm(imm), .alu_op(alu_op),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    logic [7:0] f;
    f    = ins[7:0];
    e    = '0;
    e.ra = ins[11:8];
    e.rb = ins[3:0];
    e.wa = ins[11:8];
    case (ins[15:12])
      4'h0: begin e.alu = ins[7:4]; e.rwe = (ins[7:4] != 4'hB); e.fwe = 1'b1; end
      4'h5, 4'h9: begin e.ri = 1'b1; e.alu = ins[15:12]; e.imm = {{8{f[7]}}, f}; e.rwe = 1'b1; e.fwe = 1'b1; end
      4'hB: begin e.ri = 1'b1; e.alu = 4'hB; e.imm = {{8{f[7]}}, f}; e.rwe = 1'b0; e.fwe = 1'b1; end
      4'h1, 4'h2, 4'h3: begin e.ri = 1'b1; e.alu = ins[15:12]; e.imm = {8'h00, f}; e.rwe = 1'b1; e.fwe = 1'b1; end
      4'hD: begin e.ri = 1'b1; e.alu = 4'hD; e.imm = {8'h00, f}; e.rwe = 1'b1; e.fwe = 1'b0; end
      4'hF: begin e.ri = 1'b1; e.alu = 4'hF; e.imm = {f, 8'h00}; e.rwe = 1'b1; e.fwe = 1'b0; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Issues one instruction from IDLE and follows it through EXEC and WB.
  task automatic run_one(input logic [15:0] ins);
    exp_t e;
    logic [32:0] dec_exp;
    int w;
    w = 0;
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait instr=%h: instr_ready=%b, want 1", ins, instr_ready);
      return;
    end
    instr = ins; instr_valid = 1'b1;
    sb_q.push_back(model(ins));
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    e = sb_q[0];
    dec_exp = {e.ra, e.rb, e.wa, e.ri, e.imm, e.alu};
    n_checks++;
    if ({instr_ready, reg_we, flag_we, done, illegal} !== 5'b0) begin
      n_fail++;
      $display("FAIL exec_ctrl instr=%h: rdy/rwe/fwe/done/ill=%b, want 00000", ins, {instr_ready, reg_we, flag_we, done, illegal});
    end
    if (!e.ill) begin
      n_checks++;
      if (dec_obs !== dec_exp) begin
        n_fail++;
        $display("FAIL exec_decode instr=%h: got %h, want %h", ins, dec_obs, dec_exp);
      end
    end
    w = 0;
    while (!(done || illegal) && w < 4) begin @(negedge clk); w++; end
    n_checks++;
    if (!(done || illegal) || w != 1) begin
      n_fail++;
      $display("FAIL wb_latency instr=%h: pulse after %0d cycles, want 1", ins, w);
      if (!(done || illegal)) begin void'(sb_q.pop_front()); return; end
    end
    e = sb_q.pop_front();
    n_checks++;
    if ({reg_we, flag_we, done, illegal} !== {e.rwe, e.fwe, !e.ill, e.ill}) begin
      n_fail++;
      $display("FAIL wb_pulses instr=%h: rwe/fwe/done/ill=%b, want %b", ins, {reg_we, flag_we, done, illegal}, {e.rwe, e.fwe, !e.ill, e.ill});
    end
    if (!e.ill) begin
      n_checks++;
      if (dec_obs !== dec_exp) begin
        n_fail++;
        $display("FAIL wb_decode instr=%h: got %h, want %h", ins, dec_obs, dec_exp);
      end
    end
    $display("txn instr=%h waddr=%0d ri=%b imm=%h alu_op=%h reg_we=%b flag_we=%b done=%b illegal=%b",
             ins, waddr, ri, imm, alu_op, reg_we, flag_we, done, illegal);
    @(negedge clk);
    n_checks++;
    if ({instr_ready, reg_we, flag_we, done, illegal} !== 5'b10000) begin
      n_fail++;
      $display("FAIL post_wb instr=%h: rdy/rwe/fwe/done/ill=%b, want 10000", ins, {instr_ready, reg_we, flag_we, done, illegal});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", all_outs);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL release_ready: instr_ready=%b, want 0", instr_ready);
    end
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: instr_ready=%b, want 1", instr_ready);
    end
  endtask

  task automatic test_rtype;
    run_one(16'h0355);  // ADD r3,r5
    run_one(16'h02B3);  // CMP r2,r3
    run_one(16'h0A7C);  // opext 0111 forwarded as-is
    run_one(16'h3055);  // XORI r0,#0x55
  endtask

  task automatic test_itype;
    run_one(16'h52FF);  // ADDI r2,#-1
    run_one(16'h12FF);  // ANDI r2,#0xFF
    run_one(16'hB410);  // CMPI r4,#0x10
    run_one(16'hF1AB);  // LUI r1,#0xAB
    run_one(16'h927F);  // SUBI r2,#0x7F
    run_one(16'h5180);  // ADDI r1,#-128
    run_one(16'hD380);  // MOVI r3,#0x80
    run_one(16'h2E5A);  // ORI r14,#0x5A
  endtask

  task automatic test_illegal;
    run_one(16'h7000);
    run_one(16'hE123);
    run_one(16'h4FFF);
  endtask

  task automatic test_reset_abort;
    int w;
    w = 0;
    while (!instr_ready && w < 10) begin @(negedge clk); w++; end
    instr = 16'h0355; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %h, want 0", all_outs);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({reg_we, flag_we, done, illegal} !== 4'b0) begin
        n_fail++;
        $display("FAIL abort_hold: rwe/fwe/done/ill=%b, want 0000", {reg_we, flag_we, done, illegal});
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({instr_ready, reg_we, flag_we, done, illegal} !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_release: rdy/rwe/fwe/done/ill=%b, want 00000", {instr_ready, reg_we, flag_we, done, illegal});
    end
    @(negedge clk);
    n_checks++;
    if ({instr_ready, reg_we, flag_we, done, illegal} !== 5'b10000) begin
      n_fail++;
      $display("FAIL abort_after: rdy/rwe/fwe/done/ill=%b, want 10000", {instr_ready, reg_we, flag_we, done, illegal});
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] stream [4];
    exp_t e;
    int idx, ndone, last;
    stream[0] = 16'h0355; stream[1] = 16'h52FF; stream[2] = 16'hB410; stream[3] = 16'hF1AB;
    idx = 0; ndone = 0; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (done || illegal) begin
        ndone++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: unexpected pulse at cycle %0d, want none", c);
        end else begin
          e = sb_q.pop_front();
          if ({reg_we, flag_we, done, illegal, waddr, imm} !== {e.rwe, e.fwe, !e.ill, e.ill, e.wa, e.imm}) begin
            n_fail++;
            $display("FAIL b2b_wb: got %h, want %h", {reg_we, flag_we, done, illegal, waddr, imm}, {e.rwe, e.fwe, !e.ill, e.ill, e.wa, e.imm});
          end
          $display("txn b2b waddr=%0d imm=%h reg_we=%b flag_we=%b done=%b", waddr, imm, reg_we, flag_we, done);
        end
        if (last >= 0) begin
          n_checks++;
          if (c - last != GAP) begin
            n_fail++;
            $display("FAIL b2b_spacing: gap %0d, want %0d", c - last, GAP);
          end
        end
        last = c;
      end
      if (instr_ready && idx < 4) begin
        instr = stream[idx]; instr_valid = 1'b1;
        sb_q.push_back(model(stream[idx]));
        idx++;
      end else begin
        if (idx >= 4) instr_valid = 1'b0;
        instr = 16'h7000;  // junk while not ready; must be ignored
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    n_checks++;
    if (ndone != 4) begin
      n_fail++;
      $display("FAIL b2b_count: %0d pulses, want 4", ndone);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_pending: %0d left in scoreboard, want 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_itype();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
